// File: rtl/radix_multiplier_if.sv
// Request/response bundle for the radix shift-add multiplier.
interface radix_multiplier_if #(
  parameter int unsigned WIDTH = 256
);
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               valid_in;
  logic [2*WIDTH-1:0] c_out;
  logic               valid_out;
  logic               busy_out;

  modport master (
    output a_in, b_in, valid_in,
    input  c_out, valid_out, busy_out
  );

  modport slave (
    input  a_in, b_in, valid_in,
    output c_out, valid_out, busy_out
  );
endinterface

// File: rtl/radix_multiplier.sv
// Sequential shift-add multiplier retiring DIGIT multiplier bits per cycle,
// with operand latching on accept and optional early termination.
module radix_multiplier #(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned DIGIT      = 4,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  radix_multiplier_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t          state;
  logic [PW-1:0]   a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   c_r;
  logic            valid_r;
  logic            busy_r;

  logic [PW-1:0]    pp_c;
  logic [WIDTH-1:0] b_next_c;
  logic             done_c;

  // Partial product of the shifted multiplicand and the current multiplier digit.
  always_comb begin
    pp_c = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (b_reg[i]) pp_c = pp_c + (a_reg << i);
    end
  end

  // Completion on the last digit, or early once no nonzero digits remain.
  always_comb begin
    b_next_c = b_reg >> DIGIT;
    done_c   = (count == CW'(N - 1)) || (EARLY_EXIT && (b_next_c == '0));
  end

  // Control state and datapath registers; valid pulse defaults low each edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      c_r     <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            a_reg  <= PW'(bus.a_in);
            b_reg  <= bus.b_in;
            acc    <= '0;
            count  <= '0;
            busy_r <= 1'b1;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc   <= acc + pp_c;
          a_reg <= a_reg << DIGIT;
          b_reg <= b_next_c;
          count <= count + CW'(1);
          if (done_c) begin
            c_r     <= acc + pp_c;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.c_out     = c_r;
  assign bus.valid_out = valid_r;
  assign bus.busy_out  = busy_r;

endmodule

// File: tb/tb_radix_multiplier.sv
// Directed and swept checks of radix_multiplier across digit sizes and exit modes.
module tb_radix_multiplier;

  localparam int unsigned W = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] a, b;
  logic         v;

  int n_checks = 0;
  int n_fail   = 0;

  radix_multiplier_if #(.WIDTH(W)) fbus ();
  radix_multiplier_if #(.WIDTH(W)) ebus ();

  assign fbus.a_in = a;
  assign fbus.b_in = b;
  assign fbus.valid_in = v;
  assign ebus.a_in = a;
  assign ebus.b_in = b;
  assign ebus.valid_in = v;

  radix_multiplier #(.WIDTH(W), .DIGIT(4), .EARLY_EXIT(1'b0)) u_full (
    .clk_in(clk), .rst_in(rst), .bus(fbus.slave)
  );
  radix_multiplier #(.WIDTH(W), .DIGIT(4), .EARLY_EXIT(1'b1)) u_early (
    .clk_in(clk), .rst_in(rst), .bus(ebus.slave)
  );

  // Small 8-bit instances: DIGIT 1,2,4,8 with exit mode off, on, off, on.
  logic [7:0]  sa, sb;
  logic        sv;
  logic [15:0] s_c [4];
  logic        s_vo [4];
  logic        s_bo [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_small
    radix_multiplier_if #(.WIDTH(8)) sbus ();
    assign sbus.a_in = sa;
    assign sbus.b_in = sb;
    assign sbus.valid_in = sv;
    assign s_c[gi]  = sbus.c_out;
    assign s_vo[gi] = sbus.valid_out;
    assign s_bo[gi] = sbus.busy_out;
    radix_multiplier #(.WIDTH(8), .DIGIT(1 << gi), .EARLY_EXIT((gi % 2) == 1)) u_dut (
      .clk_in(clk), .rst_in(rst), .bus(sbus.slave)
    );
  end

  // Observations recorded by run_op for the two wide instances.
  int           f_n, e_n;
  int           f_lat [2];
  int           e_lat [2];
  logic [511:0] f_c [2];
  logic [511:0] e_c [2];
  logic         f_busy0, e_busy0, f_busy_v, e_busy_v;

  // Observations recorded by run_small.
  int          s_lat [4];
  logic [15:0] s_cc [4];

  task automatic run_op(input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic [W-1:0] a2, input logic [W-1:0] b2,
                        input bit hold, input int inj, input int win);
    f_n = 0; e_n = 0;
    f_lat = '{-1, -1}; e_lat = '{-1, -1};
    f_c = '{default: '0}; e_c = '{default: '0};
    f_busy_v = 1'b1; e_busy_v = 1'b1;
    @(negedge clk);
    a = a1; b = b1; v = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc <= win; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        f_busy0 = fbus.busy_out;
        e_busy0 = ebus.busy_out;
        if (hold) begin a = a2; b = b2; end
        else v = 1'b0;
      end
      if (inj > 0 && cyc == inj - 1) begin a = a2; b = b2; v = 1'b1; end
      if (inj > 0 && cyc == inj) v = 1'b0;
      if (fbus.valid_out) begin
        if (f_n < 2) begin
          f_lat[f_n] = cyc; f_c[f_n] = fbus.c_out;
          if (f_n == 0) f_busy_v = fbus.busy_out;
        end
        f_n++;
      end
      if (ebus.valid_out) begin
        if (e_n < 2) begin
          e_lat[e_n] = cyc; e_c[e_n] = ebus.c_out;
          if (e_n == 0) e_busy_v = ebus.busy_out;
        end
        e_n++;
      end
      if (hold && f_n == 1 && cyc == f_lat[0] + 1) v = 1'b0;
      if (cyc < win) @(posedge clk);
    end
    v = 1'b0;
  endtask

  task automatic run_small(input logic [7:0] x, input logic [7:0] y);
    s_lat = '{-1, -1, -1, -1};
    s_cc  = '{default: '0};
    @(negedge clk);
    sa = x; sb = y; sv = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (cyc == 0) sv = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (s_vo[i] && s_lat[i] < 0) begin
          s_lat[i] = cyc; s_cc[i] = s_c[i];
        end
      end
      if (cyc < 9) @(posedge clk);
    end
  endtask

  // Expected completion latency for the 8-bit instances.
  function automatic int exp_lat(input int dg, input bit ee, input logic [7:0] y);
    int n, top;
    logic [7:0] m;
    n = 8 / dg;
    if (!ee) return n;
    m = 8'((9'd1 << dg) - 9'd1);
    top = 0;
    for (int j = 0; j < n; j++) begin
      if (((y >> (j * dg)) & m) != 8'd0) top = j;
    end
    return top + 1;
  endfunction

  task automatic test_reset;
    rst = 1'b1; v = 1'b0; a = '0; b = '0; sv = 1'b0; sa = '0; sb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({fbus.c_out, fbus.valid_out, fbus.busy_out} !== '0) begin
      n_fail++; $display("FAIL reset_full: c=%0h valid=%b busy=%b, required all 0", fbus.c_out, fbus.valid_out, fbus.busy_out);
    end
    n_checks++;
    if ({ebus.c_out, ebus.valid_out, ebus.busy_out} !== '0) begin
      n_fail++; $display("FAIL reset_early: c=%0h valid=%b busy=%b, required all 0", ebus.c_out, ebus.valid_out, ebus.busy_out);
    end
    n_checks++;
    if ({s_c[0], s_vo[0], s_bo[0]} !== 18'd0) begin
      n_fail++; $display("FAIL reset_small: c=%0h valid=%b busy=%b, required all 0", s_c[0], s_vo[0], s_bo[0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_op(W'(3), W'(5), '0, '0, 1'b0, 0, 68);
    n_checks++;
    if (f_busy0 !== 1'b1 || e_busy0 !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_after_accept: full=%b early=%b, required 1", f_busy0, e_busy0);
    end
    n_checks++;
    if (f_lat[0] !== 64 || f_c[0] !== 512'd15) begin
      n_fail++; $display("FAIL basic_full: lat=%0d c=%0d, required lat=64 c=15", f_lat[0], f_c[0]);
    end
    n_checks++;
    if (f_n !== 1 || f_busy_v !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: pulses=%0d busy_at_valid=%b, required 1 and 0", f_n, f_busy_v);
    end
    n_checks++;
    if (e_lat[0] !== 1 || e_c[0] !== 512'd15 || e_n !== 1) begin
      n_fail++; $display("FAIL basic_early: lat=%0d c=%0d pulses=%0d, required lat=1 c=15 pulses=1", e_lat[0], e_c[0], e_n);
    end
    n_checks++;
    if (fbus.c_out !== 512'd15) begin
      n_fail++; $display("FAIL basic_hold: c=%0d, required 15", fbus.c_out);
    end
  endtask

  task automatic test_max;
    logic [511:0] exp;
    exp = 512'd0 - (512'd1 << 257) + 512'd1;
    run_op('1, '1, '0, '0, 1'b0, 0, 68);
    n_checks++;
    if (f_lat[0] !== 64 || f_c[0] !== exp) begin
      n_fail++; $display("FAIL max_full: lat=%0d c=%0h, required lat=64 c=%0h", f_lat[0], f_c[0], exp);
    end
    n_checks++;
    if (e_lat[0] !== 64 || e_c[0] !== exp) begin
      n_fail++; $display("FAIL max_early: lat=%0d c=%0h, required lat=64 c=%0h", e_lat[0], e_c[0], exp);
    end
  endtask

  task automatic test_early_exit;
    run_op(W'(7), W'(5), '0, '0, 1'b0, 0, 68);
    n_checks++;
    if (e_lat[0] !== 1 || e_c[0] !== 512'd35 || f_c[0] !== 512'd35) begin
      n_fail++; $display("FAIL early_7x5: lat=%0d c=%0d full_c=%0d, required lat=1 c=35", e_lat[0], e_c[0], f_c[0]);
    end
    run_op(W'(9), W'(0), '0, '0, 1'b0, 0, 68);
    n_checks++;
    if (e_lat[0] !== 1 || e_c[0] !== 512'd0 || f_lat[0] !== 64 || f_c[0] !== 512'd0) begin
      n_fail++; $display("FAIL early_b0: lat=%0d c=%0d full_lat=%0d, required lat=1 c=0 full_lat=64", e_lat[0], e_c[0], f_lat[0]);
    end
    run_op(W'(1), W'(1) << 255, '0, '0, 1'b0, 0, 68);
    n_checks++;
    if (e_lat[0] !== 64 || e_c[0] !== (512'd1 << 255)) begin
      n_fail++; $display("FAIL early_btop: lat=%0d c=%0h, required lat=64 c=2^255", e_lat[0], e_c[0]);
    end
    run_op(W'(2), W'(256), '0, '0, 1'b0, 0, 68);
    n_checks++;
    if (e_lat[0] !== 3 || e_c[0] !== 512'h200) begin
      n_fail++; $display("FAIL early_digit2: lat=%0d c=%0h, required lat=3 c=200", e_lat[0], e_c[0]);
    end
  endtask

  task automatic test_ignore_busy;
    run_op(W'(3), W'(1) << 255, W'(5), W'(1), 1'b0, 10, 70);
    n_checks++;
    if (f_n !== 1 || f_lat[0] !== 64 || f_c[0] !== (512'd3 << 255)) begin
      n_fail++; $display("FAIL ignore_full: pulses=%0d lat=%0d c=%0h, required 1, 64, 3*2^255", f_n, f_lat[0], f_c[0]);
    end
    n_checks++;
    if (e_n !== 1 || e_c[0] !== (512'd3 << 255) || ebus.busy_out !== 1'b0) begin
      n_fail++; $display("FAIL ignore_early: pulses=%0d c=%0h busy=%b, required 1, 3*2^255, 0", e_n, e_c[0], ebus.busy_out);
    end
  endtask

  task automatic test_back_to_back;
    run_op(W'(9), W'(1) << 255, W'(11), W'(13), 1'b1, 0, 135);
    n_checks++;
    if (f_n !== 2 || f_lat[0] !== 64 || f_c[0] !== (512'd9 << 255) || f_busy_v !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: pulses=%0d lat=%0d c=%0h busy=%b, required 2, 64, 9*2^255, 0", f_n, f_lat[0], f_c[0], f_busy_v);
    end
    n_checks++;
    if (f_lat[1] !== 129 || f_c[1] !== 512'd143) begin
      n_fail++; $display("FAIL b2b_second_full: lat=%0d c=%0d, required lat=129 c=143", f_lat[1], f_c[1]);
    end
    n_checks++;
    if (e_n !== 2 || e_lat[1] !== 66 || e_c[1] !== 512'd143) begin
      n_fail++; $display("FAIL b2b_second_early: pulses=%0d lat=%0d c=%0d, required 2, 66, 143", e_n, e_lat[1], e_c[1]);
    end
  endtask

  task automatic test_reset_abort;
    int pulses;
    pulses = 0;
    @(negedge clk);
    a = W'(5); b = W'(1) << 255; v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fbus.c_out, fbus.valid_out, fbus.busy_out, ebus.c_out, ebus.valid_out, ebus.busy_out} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: full c=%0h v=%b busy=%b early c=%0h v=%b busy=%b, required all 0",
                         fbus.c_out, fbus.valid_out, fbus.busy_out, ebus.c_out, ebus.valid_out, ebus.busy_out);
    end
    a = W'(4); b = W'(4); v = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fbus.busy_out !== 1'b0 || ebus.busy_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_vs_valid: busy full=%b early=%b, required 0", fbus.busy_out, ebus.busy_out);
    end
    rst = 1'b0; v = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (fbus.valid_out || ebus.valid_out) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL abort_no_valid: pulses=%0d, required 0", pulses);
    end
    run_op(W'(11), W'(13), '0, '0, 1'b0, 0, 68);
    n_checks++;
    if (f_lat[0] !== 64 || f_c[0] !== 512'd143 || e_lat[0] !== 1 || e_c[0] !== 512'd143) begin
      n_fail++; $display("FAIL after_abort: full lat=%0d c=%0d early lat=%0d c=%0d, required 64/143 1/143",
                         f_lat[0], f_c[0], e_lat[0], e_c[0]);
    end
  endtask

  task automatic test_small_sweep;
    logic [7:0] x, y;
    run_small(8'd255, 8'd255);
    n_checks++;
    if (s_lat[0] !== 8 || s_cc[0] !== 16'd65025) begin
      n_fail++; $display("FAIL small_max_d1: lat=%0d c=%0d, required lat=8 c=65025", s_lat[0], s_cc[0]);
    end
    for (int op = 0; op < 250; op++) begin
      x = 8'($urandom);
      y = (op % 4 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      run_small(x, y);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (s_cc[i] !== 16'(x) * 16'(y)) begin
          n_fail++; $display("FAIL sweep_c d%0d: a=%0d b=%0d c=%0d, required %0d", 1 << i, x, y, s_cc[i], 16'(x) * 16'(y));
        end
        n_checks++;
        if (s_lat[i] !== exp_lat(1 << i, (i % 2) == 1, y)) begin
          n_fail++; $display("FAIL sweep_lat d%0d: b=%0d lat=%0d, required %0d", 1 << i, y, s_lat[i], exp_lat(1 << i, (i % 2) == 1, y));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_early_exit();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_small_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
